// File: rtl/l1_l2_arbiter_pkg.sv
// Shared definitions for the L1 I/D to L2 request arbiter: state encoding,
// requester identifiers and default widths.
package l1_l2_arbiter_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int LINE_W_DEF = 512;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT_I = 2'd1,
      S_GRANT_D = 2'd2,
      S_DONE    = 2'd3
   } arb_state_e;

endpackage

// File: rtl/l1_l2_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the side that was not served last wins.
module rr_pick2
   import l1_l2_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_id
);

   always_comb begin
      gnt_id = REQ_I;
      if (req == 2'b11) begin
         gnt_id = ~last;
      end else if (req[REQ_D]) begin
         gnt_id = REQ_D;
      end
   end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Arbitrates the single L2 port between the L1 I-cache and D-cache controllers,
// one transaction in flight, with every output driven straight from a register.
module l1_l2_arbiter
   import l1_l2_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              i_read_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic [LINE_W-1:0] i_rdata,
   input  logic              d_read_req,
   input  logic              d_write_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [LINE_W-1:0] d_rdata,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_ready,
   output logic              grant_id,
   output logic              busy
);

   arb_state_e        state_q;
   logic              last_grant_q;
   logic              grant_id_q;
   logic              busy_q;
   logic              l2_read_q;
   logic              l2_write_q;
   logic [ADDR_W-1:0] l2_addr_q;
   logic [LINE_W-1:0] l2_wdata_q;
   logic              i_ready_q;
   logic              d_ready_q;
   logic [LINE_W-1:0] i_rdata_q;
   logic [LINE_W-1:0] d_rdata_q;

   logic [1:0]        req_d;
   logic              gnt_id_d;

   assign req_d = {d_read_req | d_write_req, i_read_req};

   rr_pick2 u_pick (
      .req    (req_d),
      .last   (last_grant_q),
      .gnt_id (gnt_id_d)
   );

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q      <= S_IDLE;
         last_grant_q <= REQ_I;
         grant_id_q   <= REQ_I;
         busy_q       <= 1'b0;
         l2_read_q    <= 1'b0;
         l2_write_q   <= 1'b0;
         l2_addr_q    <= '0;
         l2_wdata_q   <= '0;
         i_ready_q    <= 1'b0;
         d_ready_q    <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|req_d) begin
                  busy_q       <= 1'b1;
                  grant_id_q   <= gnt_id_d;
                  last_grant_q <= gnt_id_d;
                  if (gnt_id_d == REQ_D) begin
                     // A pending write-back goes ahead of the D-side read.
                     state_q    <= S_GRANT_D;
                     l2_addr_q  <= d_addr;
                     l2_wdata_q <= d_wdata;
                     l2_write_q <= d_write_req;
                     l2_read_q  <= ~d_write_req;
                  end else begin
                     state_q    <= S_GRANT_I;
                     l2_addr_q  <= i_addr;
                     l2_wdata_q <= '0;
                     l2_write_q <= 1'b0;
                     l2_read_q  <= 1'b1;
                  end
               end
            end
            S_GRANT_I, S_GRANT_D: begin
               if (l2_ready) begin
                  l2_read_q  <= 1'b0;
                  l2_write_q <= 1'b0;
                  state_q    <= S_DONE;
                  if (state_q == S_GRANT_I) begin
                     i_rdata_q <= l2_rdata;
                     i_ready_q <= 1'b1;
                  end else begin
                     d_rdata_q <= l2_rdata;
                     d_ready_q <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               // Requests are ignored here so the owner can drop its level request.
               i_ready_q <= 1'b0;
               d_ready_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign l2_read  = l2_read_q;
   assign l2_write = l2_write_q;
   assign l2_addr  = l2_addr_q;
   assign l2_wdata = l2_wdata_q;
   assign i_ready  = i_ready_q;
   assign d_ready  = d_ready_q;
   assign i_rdata  = i_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign grant_id = grant_id_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Scoreboard bench for l1_l2_arbiter: directed L1 traffic, a small L2 responder,
// and a monitor that checks each L2 request and each completion pulse.
module tb_l1_l2_arbiter;

   localparam int AW = 32;
   localparam int LW = 512;

   logic          clk = 1'b0;
   logic          nrst;
   logic          i_read_req, d_read_req, d_write_req;
   logic [AW-1:0] i_addr, d_addr;
   logic [LW-1:0] d_wdata;
   logic          i_ready, d_ready;
   logic [LW-1:0] i_rdata, d_rdata;
   logic          l2_read, l2_write;
   logic [AW-1:0] l2_addr;
   logic [LW-1:0] l2_wdata, l2_rdata;
   logic          l2_ready;
   logic          grant_id, busy;

   l1_l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk(clk), .nrst(nrst),
      .i_read_req(i_read_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_read_req(d_read_req), .d_write_req(d_write_req), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
      .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
      .l2_rdata(l2_rdata), .l2_ready(l2_ready), .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          id;
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
   } l2_exp_t;

   typedef struct {
      logic          id;
      logic [LW-1:0] rdata;
   } rdy_exp_t;

   l2_exp_t  l2_q[$];
   rdy_exp_t rdy_q[$];

   int errors = 0;
   int checks = 0;
   int l2_delay = 1;
   logic stray = 1'b0;

   function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
      return {16{a ^ 32'hA5A5_0000}};
   endfunction

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_l2(input logic id, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
      l2_exp_t e;
      e.id = id; e.wr = wr; e.addr = a; e.wdata = wd;
      l2_q.push_back(e);
   endtask

   task automatic push_rdy(input logic id, input logic [LW-1:0] rd);
      rdy_exp_t e;
      e.id = id; e.rdata = rd;
      rdy_q.push_back(e);
   endtask

   // L2 responder: l2_ready l2_delay cycles after a request appears, plus an optional stray pulse.
   initial begin
      int wait_c;
      wait_c   = -1;
      l2_ready = 1'b0;
      l2_rdata = '0;
      forever begin
         @(negedge clk);
         l2_ready = 1'b0;
         if (l2_read || l2_write) begin
            if (wait_c < 0) wait_c = l2_delay - 1;
            else wait_c--;
            if (wait_c == 0) begin
               l2_ready = 1'b1;
               l2_rdata = pat(l2_addr);
            end
         end else begin
            wait_c = -1;
            if (stray) begin
               l2_ready = 1'b1;
               l2_rdata = {16{32'hDEAD_BEEF}};
               stray    = 1'b0;
            end
         end
      end
   end

   // Monitor: compares each new L2 request and each ready pulse against the queues.
   initial begin
      logic prev_req;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         check("l2_rw_exclusive", LW'(l2_read & l2_write), '0);
         check("ready_exclusive", LW'(i_ready & d_ready), '0);
         if ((l2_read || l2_write) && !prev_req) begin
            if (l2_q.size() == 0) begin
               check("l2_unexpected_request", LW'(1), LW'(0));
            end else begin
               l2_exp_t e;
               e = l2_q.pop_front();
               check("l2_grant_id", LW'(grant_id), LW'(e.id));
               check("l2_write", LW'(l2_write), LW'(e.wr));
               check("l2_read", LW'(l2_read), LW'(!e.wr));
               check("l2_addr", LW'(l2_addr), LW'(e.addr));
               if (e.wr) check("l2_wdata", l2_wdata, e.wdata);
            end
         end
         prev_req = l2_read | l2_write;
         if (i_ready || d_ready) begin
            if (rdy_q.size() == 0) begin
               check("unexpected_ready", {d_ready, i_ready}, '0);
            end else begin
               rdy_exp_t r;
               r = rdy_q.pop_front();
               check("ready_side", {d_ready, i_ready}, r.id ? LW'(2'b10) : LW'(2'b01));
               check("ready_rdata", r.id ? d_rdata : i_rdata, r.rdata);
            end
         end
      end
   end

   task automatic run_txn(input logic ir, input logic dr, input logic dw,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic [LW-1:0] wd);
      int n;
      i_addr = ia; d_addr = da; d_wdata = wd;
      i_read_req = ir; d_read_req = dr; d_write_req = dw;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (i_ready) i_read_req = 1'b0;
         if (d_ready) begin
            if (d_write_req) d_write_req = 1'b0;
            else d_read_req = 1'b0;
         end
         if (!i_read_req && !d_read_req && !d_write_req && !busy) break;
      end
      if (n >= 200) check("txn_timeout", LW'(1), LW'(0));
   endtask

   task automatic wait_idle();
      int n;
      for (n = 0; n < 100 && busy; n++) @(negedge clk);
      if (n >= 100) check("idle_timeout", LW'(1), LW'(0));
   endtask

   initial begin
      logic [LW-1:0] wd_b;
      int n, seen;
      wd_b = {16{32'hB0B0_0001}};
      nrst = 1'b0;
      i_read_req = 0; d_read_req = 0; d_write_req = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", LW'(busy), '0);
      check("rst_l2_read", LW'(l2_read), '0);
      check("rst_readies", LW'({i_ready, d_ready}), '0);
      check("rst_grant_id", LW'(grant_id), '0);
      check("rst_l2_addr", LW'(l2_addr), '0);
      nrst = 1'b1;
      @(negedge clk);

      // I-only read, L2 answers after 4 cycles; request reaches L2 one cycle after sampling
      l2_delay = 4;
      push_l2(1'b0, 1'b0, 32'h0000_1040, '0);
      push_rdy(1'b0, pat(32'h0000_1040));
      i_addr = 32'h0000_1040; i_read_req = 1'b1;
      @(negedge clk);
      check("t1_latency_l2_read", LW'({l2_read, busy, grant_id}), LW'(3'b110));
      run_txn(1'b1, 1'b0, 1'b0, 32'h0000_1040, '0, '0);

      // Tie (last served was I) -> D first, then I
      l2_delay = 2;
      push_l2(1'b1, 1'b0, 32'h0000_3000, '0);
      push_rdy(1'b1, pat(32'h0000_3000));
      push_l2(1'b0, 1'b0, 32'h0000_1080, '0);
      push_rdy(1'b0, pat(32'h0000_1080));
      run_txn(1'b1, 1'b1, 1'b0, 32'h0000_1080, 32'h0000_3000, '0);
      check("t2_d_rdata_held", d_rdata, pat(32'h0000_3000));

      // D write-back and read together: write first, read as its own grant
      push_l2(1'b1, 1'b1, 32'h0000_2080, wd_b);
      push_rdy(1'b1, pat(32'h0000_2080));
      push_l2(1'b1, 1'b0, 32'h0000_2080, '0);
      push_rdy(1'b1, pat(32'h0000_2080));
      run_txn(1'b0, 1'b1, 1'b1, '0, 32'h0000_2080, wd_b);
      check("t3_i_rdata_held", i_rdata, pat(32'h0000_1080));

      // Reset in the middle of an I grant
      l2_delay = 10;
      push_l2(1'b0, 1'b0, 32'h0000_6000, '0);
      i_addr = 32'h0000_6000; i_read_req = 1'b1;
      repeat (2) @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1; i_read_req = 1'b0;
      check("t5_rst_ctrl", LW'({l2_read, l2_write, i_ready, d_ready, busy, grant_id}), '0);
      check("t5_rst_l2_addr", LW'(l2_addr), '0);
      check("t5_rst_i_rdata", i_rdata, '0);
      check("t5_rst_d_rdata", d_rdata, '0);
      @(negedge clk);
      check("t5_idle_after_rst", LW'(busy), '0);

      // Both request continuously: after reset grants run D,I,D,I,D,I
      l2_delay = 1;
      for (int k = 0; k < 3; k++) begin
         push_l2(1'b1, 1'b0, 32'h0000_5000, '0);
         push_rdy(1'b1, pat(32'h0000_5000));
         push_l2(1'b0, 1'b0, 32'h0000_4000, '0);
         push_rdy(1'b0, pat(32'h0000_4000));
      end
      i_addr = 32'h0000_4000; d_addr = 32'h0000_5000;
      i_read_req = 1'b1; d_read_req = 1'b1;
      seen = 0;
      for (n = 0; n < 200 && seen < 6; n++) begin
         @(negedge clk);
         if (i_ready || d_ready) seen++;
      end
      i_read_req = 1'b0; d_read_req = 1'b0;
      check("t4_six_completions", LW'(seen), LW'(6));
      wait_idle();

      // Requester drops mid-grant, then a stray l2_ready in idle
      l2_delay = 5;
      push_l2(1'b0, 1'b0, 32'h0000_7040, '0);
      push_rdy(1'b0, pat(32'h0000_7040));
      i_addr = 32'h0000_7040; i_read_req = 1'b1;
      repeat (2) @(negedge clk);
      i_read_req = 1'b0;
      seen = 0;
      for (n = 0; n < 50 && seen == 0; n++) begin
         @(negedge clk);
         if (i_ready) seen = 1;
      end
      check("t6_ready_after_drop", LW'(seen), LW'(1));
      wait_idle();
      @(negedge clk);
      stray = 1'b1;
      repeat (4) @(negedge clk);
      check("t6_stray_no_state", LW'({busy, l2_read, l2_write}), '0);
      check("t6_stray_i_rdata_held", i_rdata, pat(32'h0000_7040));

      repeat (2) @(negedge clk);
      check("l2_queue_drained", LW'(l2_q.size()), '0);
      check("ready_queue_drained", LW'(rdy_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
